// File: rtl/digital_clock_pkg.sv
// Shared types and BCD helpers for the digital clock datapath.
// Vectors are passed zero-extended to eight digits so one helper serves every width.
package digital_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX    = 9;
  localparam int MAX_DIGITS = 8;

  function automatic int bcdToInt(input logic [4*MAX_DIGITS-1:0] v, input int numDigits);
    int acc;
    acc = 0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < numDigits) acc = acc * 10 + int'({28'd0, v[4*i +: 4]});
    end
    return acc;
  endfunction

  function automatic logic bcdValid(input logic [4*MAX_DIGITS-1:0] v, input int numDigits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < numDigits && int'({28'd0, v[4*i +: 4]}) > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [4*MAX_DIGITS-1:0] intToBcd(input int value);
    logic [4*MAX_DIGITS-1:0] r;
    int rem;
    r   = '0;
    rem = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stage: computes the stepped digit and the ripple carry/borrow.
module bcd_digit
  import digital_clock_pkg::*;
(
  input  logic [3:0] cur,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic       carry_out,
  output logic       borrow_out,
  output logic [3:0] digit
);

  always_comb begin
    digit      = cur;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (inc && carry_in) begin
      if (cur >= 4'(BCD_MAX)) begin
        digit     = 4'd0;
        carry_out = 1'b1;
      end else begin
        digit = cur + 4'd1;
      end
    end else if (dec && borrow_in) begin
      if (cur == 4'd0) begin
        digit      = 4'(BCD_MAX);
        borrow_out = 1'b1;
      end else begin
        digit = cur - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Cascadable N-digit BCD modulo counter with validated synchronous load.
// Optional down counting and the up_dn port are enabled by BCD_COUNTER_DOWN_EN.
module bcd_mod_counter
  import digital_clock_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int MODULUS    = 60
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    en,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                    up_dn,
`endif
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry_out,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [4*MAX_DIGITS-1:0] MAX_BCD = intToBcd(MODULUS - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_badDigits
      $error("bcd_mod_counter: NUM_DIGITS out of range 1..8");
    end
    if (MODULUS < 2 || longint'(MODULUS) > 64'(10) ** NUM_DIGITS) begin : g_badModulus
      $error("bcd_mod_counter: MODULUS out of range 2..10**NUM_DIGITS");
    end
  endgenerate

  logic [W-1:0]        count_q, count_d;
  logic                loadErr_q, loadErr_d;
  logic [W-1:0]        rippled;
  logic [NUM_DIGITS:0] carryChain;
  logic [NUM_DIGITS:0] borrowChain;
  logic                upMode;
  logic                atMax;
  logic                loadOk;
  logic                unusedChainTop;

`ifdef BCD_COUNTER_DOWN_EN
  logic atZero;
  assign upMode = up_dn;
  assign atZero = (count_q == '0);
`else
  assign upMode = 1'b1;
`endif

  assign atMax  = (bcdToInt(32'(count_q), NUM_DIGITS) == MODULUS - 1);
  assign loadOk = bcdValid(32'(load_value), NUM_DIGITS) &&
                  (bcdToInt(32'(load_value), NUM_DIGITS) < MODULUS);

  // The lowest digit always steps; higher digits step only on a ripple from below.
  assign carryChain[0]  = 1'b1;
  assign borrowChain[0] = 1'b1;
  assign unusedChainTop = carryChain[NUM_DIGITS] ^ borrowChain[NUM_DIGITS];

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .cur        (count_q[4*g +: 4]),
        .inc        (upMode),
        .dec        (~upMode),
        .carry_in   (carryChain[g]),
        .borrow_in  (borrowChain[g]),
        .carry_out  (carryChain[g+1]),
        .borrow_out (borrowChain[g+1]),
        .digit      (rippled[4*g +: 4])
      );
    end
  endgenerate

  // Load beats count; the modulus override replaces the plain BCD ripple at the wrap points.
  always_comb begin
    count_d   = count_q;
    loadErr_d = 1'b0;
    if (load) begin
      if (loadOk) count_d = load_value;
      else        loadErr_d = 1'b1;
    end else if (en) begin
`ifdef BCD_COUNTER_DOWN_EN
      if (upMode) count_d = atMax  ? '0 : rippled;
      else        count_d = atZero ? MAX_BCD[W-1:0] : rippled;
`else
      count_d = atMax ? '0 : rippled;
`endif
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q   <= '0;
      loadErr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      loadErr_q <= loadErr_d;
    end
  end

`ifdef BCD_COUNTER_DOWN_EN
  assign carry_out = ~clear & en & ~load & (upMode ? atMax : atZero);
`else
  assign carry_out = ~clear & en & ~load & atMax;
`endif

  assign count    = count_q;
  assign load_err = loadErr_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: mod-60 stage against an arithmetic model,
// plus an H:M:S cascade and a mod-6 single-digit instance.
module tb_bcd_mod_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear = 1'b0;

  logic       en = 1'b0, load = 1'b0, upDn = 1'b1;
  logic [7:0] loadValue = 8'h00;
  logic [7:0] count;
  logic       carryOut, loadErr;

  logic       casEn = 1'b0, casLoad = 1'b0;
  logic [7:0] secLoad = 8'h00, minLoad = 8'h00, hrLoad = 8'h00;
  logic [7:0] secCount, minCount, hrCount;
  logic       secCarry, minCarry, hrCarry;
  logic       secErr, minErr, hrErr;

  logic       m6En = 1'b0, m6Load = 1'b0;
  logic [3:0] m6LoadValue = 4'h0;
  logic [3:0] m6Count;
  logic       m6Carry, m6Err;

  bcd_mod_counter #(.NUM_DIGITS(2), .MODULUS(60)) dut (
    .clock(clock), .clear(clear), .en(en),
`ifdef BCD_COUNTER_DOWN_EN
    .up_dn(upDn),
`endif
    .load(load), .load_value(loadValue),
    .count(count), .carry_out(carryOut), .load_err(loadErr)
  );

  bcd_mod_counter #(.NUM_DIGITS(2), .MODULUS(60)) u_sec (
    .clock(clock), .clear(clear), .en(casEn),
`ifdef BCD_COUNTER_DOWN_EN
    .up_dn(1'b1),
`endif
    .load(casLoad), .load_value(secLoad),
    .count(secCount), .carry_out(secCarry), .load_err(secErr)
  );

  bcd_mod_counter #(.NUM_DIGITS(2), .MODULUS(60)) u_min (
    .clock(clock), .clear(clear), .en(secCarry),
`ifdef BCD_COUNTER_DOWN_EN
    .up_dn(1'b1),
`endif
    .load(casLoad), .load_value(minLoad),
    .count(minCount), .carry_out(minCarry), .load_err(minErr)
  );

  bcd_mod_counter #(.NUM_DIGITS(2), .MODULUS(24)) u_hr (
    .clock(clock), .clear(clear), .en(minCarry),
`ifdef BCD_COUNTER_DOWN_EN
    .up_dn(1'b1),
`endif
    .load(casLoad), .load_value(hrLoad),
    .count(hrCount), .carry_out(hrCarry), .load_err(hrErr)
  );

  bcd_mod_counter #(.NUM_DIGITS(1), .MODULUS(6)) u_mod6 (
    .clock(clock), .clear(clear), .en(m6En),
`ifdef BCD_COUNTER_DOWN_EN
    .up_dn(1'b1),
`endif
    .load(m6Load), .load_value(m6LoadValue),
    .count(m6Count), .carry_out(m6Carry), .load_err(m6Err)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the mod-60 stage kept as a plain integer 0..59.
  int   modelVal = 0;
  logic modelErr = 1'b0;
  logic checkEnable = 1'b0;

  function automatic logic modelUp();
`ifdef BCD_COUNTER_DOWN_EN
    return upDn;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic loadValid(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo < 60);
  endfunction

  function automatic logic [7:0] toBcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      modelVal <= 0;
      modelErr <= 1'b0;
    end else begin
      modelErr <= 1'b0;
      if (load) begin
        if (loadValid(loadValue)) modelVal <= int'(loadValue[7:4]) * 10 + int'(loadValue[3:0]);
        else                      modelErr <= 1'b1;
      end else if (en) begin
        modelVal <= modelUp() ? (modelVal + 1) % 60 : (modelVal + 59) % 60;
      end
    end
  end

  always @(negedge clock) begin
    if (checkEnable) begin
      checkOutput("model count", 32'(count), 32'(toBcd(modelVal)));
      checkOutput("model load_err", 32'(loadErr), 32'(modelErr));
      checkOutput("model carry_out", 32'(carryOut),
                  32'(!clear && en && !load && (modelUp() ? (modelVal == 59) : (modelVal == 0))));
    end
  end

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int carries;
    #1 clear = 1'b1;
    checkEnable = 1'b1;
    applyStimulus();
    checkOutput("reset count", 32'(count), 32'h00);
    checkOutput("reset load_err", 32'(loadErr), 32'h0);
    checkOutput("reset carry", 32'(carryOut), 32'h0);
    applyStimulus();
    clear = 1'b0;

    // Up wrap through 59 -> 00
    load = 1'b1; loadValue = 8'h58;
    applyStimulus();
    load = 1'b0;
    checkOutput("load 58", 32'(count), 32'h58);
    en = 1'b1;
    #1 checkOutput("carry at 58", 32'(carryOut), 32'h0);
    applyStimulus();
    checkOutput("up 59", 32'(count), 32'h59);
    #1 checkOutput("carry at 59", 32'(carryOut), 32'h1);
    applyStimulus();
    checkOutput("wrap 00", 32'(count), 32'h00);
    #1 checkOutput("carry at 00", 32'(carryOut), 32'h0);
    applyStimulus();
    checkOutput("up 01", 32'(count), 32'h01);
    en = 1'b0;
    load = 1'b1; loadValue = 8'h09;
    applyStimulus();
    load = 1'b0; en = 1'b1;
    applyStimulus();
    en = 1'b0;
    checkOutput("digit rollover 10", 32'(count), 32'h10);

    // Rejected and accepted loads
    load = 1'b1; loadValue = 8'h60;
    applyStimulus();
    load = 1'b0;
    checkOutput("bad load 60 holds", 32'(count), 32'h10);
    checkOutput("bad load 60 err", 32'(loadErr), 32'h1);
    applyStimulus();
    checkOutput("err clears after 60", 32'(loadErr), 32'h0);
    load = 1'b1; loadValue = 8'h3A;
    applyStimulus();
    load = 1'b0;
    checkOutput("bad load 3A holds", 32'(count), 32'h10);
    checkOutput("bad load 3A err", 32'(loadErr), 32'h1);
    applyStimulus();
    checkOutput("err clears after 3A", 32'(loadErr), 32'h0);
    load = 1'b1; loadValue = 8'h59;
    applyStimulus();
    loadValue = 8'h45; en = 1'b1;
    #1 checkOutput("carry masked by load", 32'(carryOut), 32'h0);
    applyStimulus();
    load = 1'b0; en = 1'b0;
    checkOutput("load wins 45", 32'(count), 32'h45);
    checkOutput("good load no err", 32'(loadErr), 32'h0);

`ifdef BCD_COUNTER_DOWN_EN
    // Down wrap through 00 -> 59
    load = 1'b1; loadValue = 8'h01;
    applyStimulus();
    load = 1'b0; upDn = 1'b0; en = 1'b1;
    #1 checkOutput("down carry at 01", 32'(carryOut), 32'h0);
    applyStimulus();
    checkOutput("down 00", 32'(count), 32'h00);
    #1 checkOutput("down carry at 00", 32'(carryOut), 32'h1);
    applyStimulus();
    checkOutput("down wrap 59", 32'(count), 32'h59);
    en = 1'b0; upDn = 1'b1;
`endif

    // Asynchronous clear mid-count
    load = 1'b1; loadValue = 8'h36;
    applyStimulus();
    load = 1'b0; en = 1'b1;
    applyStimulus();
    checkOutput("count 37", 32'(count), 32'h37);
    #2 clear = 1'b1;
    #1;
    checkOutput("async clear count", 32'(count), 32'h00);
    checkOutput("async clear carry", 32'(carryOut), 32'h0);
    checkOutput("async clear err", 32'(loadErr), 32'h0);
    applyStimulus();
    checkOutput("clear held count", 32'(count), 32'h00);
    clear = 1'b0;
    applyStimulus();
    checkOutput("first edge after clear", 32'(count), 32'h01);
    en = 1'b0;

    // H:M:S cascade 23:59:59 -> 00:00:00
    casLoad = 1'b1; secLoad = 8'h59; minLoad = 8'h59; hrLoad = 8'h23;
    applyStimulus();
    casLoad = 1'b0; casEn = 1'b1;
    #1;
    checkOutput("cascade sec carry", 32'(secCarry), 32'h1);
    checkOutput("cascade min carry", 32'(minCarry), 32'h1);
    checkOutput("cascade hr carry", 32'(hrCarry), 32'h1);
    applyStimulus();
    casEn = 1'b0;
    checkOutput("cascade sec", 32'(secCount), 32'h00);
    checkOutput("cascade min", 32'(minCount), 32'h00);
    checkOutput("cascade hr", 32'(hrCount), 32'h00);
    checkOutput("cascade errs", 32'({secErr, minErr, hrErr}), 32'h0);
    casEn = 1'b1;
    applyStimulus();
    casEn = 1'b0;
    checkOutput("cascade sec step", 32'(secCount), 32'h01);
    checkOutput("cascade min steady", 32'(minCount), 32'h00);

    // Mod-6 single digit
    carries = 0;
    m6En = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (m6Carry) carries++;
      checkOutput("mod6 carry", 32'(m6Carry), 32'((i % 6) == 5));
      applyStimulus();
      checkOutput("mod6 count", 32'(m6Count), 32'((i + 1) % 6));
    end
    m6En = 1'b0;
    checkOutput("mod6 carry total", 32'(carries), 32'd2);
    checkOutput("mod6 err", 32'(m6Err), 32'h0);

    checkEnable = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised multi-digit BCD modulo counter for the digital clock datapath. It generalises the fixed 4-bit T-flip-flop counter to N BCD digits with any modulus, synchronous load, optional down-counting, and a cascadable carry. Chained instances form the seconds (mod 60), minutes (mod 60) and hours (mod 24) stages. Each stage's `carry_out` drives the next stage's `en`.

## Interface
- `NUM_DIGITS`, default 2: number of BCD digits. Range 1..8.
- `MODULUS`, default 60: count range 0..MODULUS-1. Requires 2 ≤ MODULUS ≤ 10^NUM_DIGITS; elaboration error otherwise.

- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `clear`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: count enable; one step per clock while high.
- `up_dn`, in, 1: 1 = count up, 0 = count down. Only present with the macro (see Configuration).
- `load`, in, 1: synchronous load request.
- `load_value`, in, 4*NUM_DIGITS: BCD value to load; digit 0 is in bits [3:0].
- `count`, out, 4*NUM_DIGITS: current BCD count, registered.
- `carry_out`, out, 1: combinational wrap indication, used for cascading.
- `load_err`, out, 1: registered one-cycle pulse when a rejected load occurs.

## Operation
- **Reset.** While `clear`=1: `count`=0, `load_err`=0, and `carry_out` is forced to 0, regardless of `clock`.
- **Priority per edge:**
  1. `load`
  2. `en`
  3. hold
- **Load, accepted case.** `load`=1 with every digit ≤ 9 and value < MODULUS: `count` ← `load_value`; `en` is ignored that cycle.
- **Load, rejected case.** `load`=1 with any digit > 9 or value ≥ MODULUS:
  - `count` holds.
  - `load_err`=1 for the next cycle.
  - `en` is also ignored that cycle; there is no count.
- **Up count** (`en`=1, up):
  - Ripple-BCD increment: a digit at 9 goes to 0 and carries into the next digit.
  - When `count` = MODULUS-1, the next value is 0 (wrap).
- **Down count** (`en`=1, down):
  - BCD decrement: a digit at 0 goes to 9 and borrows from the next digit.
  - When `count` = 0, the next value is MODULUS-1.
- **`carry_out`:**
  - Up: `en` & (`count` == MODULUS-1) & ~`load`.
  - Down: `en` & (`count` == 0) & ~`load`.
  - High exactly in the cycle whose edge performs the wrap.
- `count` never leaves 0..MODULUS-1 and never holds a non-BCD digit.

## Timing
- Load and count latency: 1 clock (the value is visible after the edge).
- `carry_out` has zero latency; it is combinational from `count`, `en`, `load` and `up_dn`. Cascading N stages adds only combinational delay, so all stages update on the same edge.
- `load_err` asserts on the edge that samples the bad load and deasserts on the following edge unless another bad load occurs.
- **`clear` asserted mid-operation:** immediate async zero; a pending load or count is discarded.
- **`clear` deasserted:** the first counting edge is the first rising edge with `clear`=0.
- **Direction change:** `up_dn` toggling between edges takes effect on the next edge. No state is carried across the change.

## Configuration
- The single feature macro is `BCD_COUNTER_DOWN_EN`.
- Defined:
  - The `up_dn` port exists.
  - The down-count and borrow logic is compiled in.
- Undefined:
  - The `up_dn` port is absent.
  - The counter is up-only; `carry_out` uses the up term only.
  - Area drops by the decrement and borrow logic.

## Structure
- Shared package `digital_clock_pkg`:
  - `bcd_digit_t` (4-bit)
  - `BCD_MAX` = 9
  - helper function for BCD-vector-to-integer compare, used for the MODULUS checks
- Sub-module `bcd_digit`: one digit with `inc`, `dec`, `carry_in` and `borrow_in` inputs, and `carry_out`, `borrow_out` and `digit` outputs. The top instantiates NUM_DIGITS of them in a generate loop. The top adds:
  - the MODULUS wrap override
  - load and validation
  - `load_err`

## Test plan
All scenarios use NUM_DIGITS=2, MODULUS=60 unless noted.
1. **Reset.** Assert `clear` mid-count at `count`=0x37 → `count`=0x00 immediately, with no clock edge needed; `carry_out`=0 and `load_err`=0 throughout.
2. **Up wrap.**
   - Load 0x58, then `en`=1 for 3 clocks → 0x59, 0x00, 0x01.
   - `carry_out`=1 only in the cycle where `count`=0x59.
   - Digit rollover from 0x09 goes to 0x10.
3. **Down wrap** (macro defined). Load 0x01, `up_dn`=0, `en`=1 → 0x00, then 0x59; `carry_out`=1 only in the cycle where `count`=0x00.
4. **Load validation.**
   - Load 0x60 → count holds and `load_err` pulses for 1 cycle.
   - Load 0x3A → same response.
   - Load 0x45 with `en`=1 → `count`=0x45 (load wins) and `carry_out`=0.
5. **Cascade.**
   - Chain seconds (mod 60), minutes (mod 60) and hours (NUM_DIGITS=2, MODULUS=24).
   - Preset 23:59:59, apply one `en` pulse → 00:00:00 on a single edge.
6. **Non-power-of-ten modulus.** With NUM_DIGITS=1, MODULUS=6, run 12 enabled clocks from 0 → sequence 1,2,3,4,5,0,1,…; `carry_out` fires twice.
